// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared constants, types and latency select for the issue scoreboard
package issue_scoreboard_pkg;

    localparam int MAX_LAT      = 7;
    localparam int ALU_LAT_DEF  = 1;
    localparam int LOAD_LAT_DEF = 3;
    localparam int MUL_LAT_DEF  = 5;
    localparam int REG_FILE_LEN = 32;
    localparam int REG_IDX_W    = $clog2(REG_FILE_LEN);
    localparam int LAT_W        = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [LAT_W-1:0]     lat_t;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     rs1_used;
        logic     rs2_used;
        reg_idx_t rd;
        logic     reg_write;
        logic     is_load;
        logic     is_mul;
    } issue_req_t;

    // Load wins when both class bits are set.
    function automatic lat_t sel_lat(input logic is_load, input logic is_mul,
                                     input lat_t alu_lat, input lat_t load_lat,
                                     input lat_t mul_lat);
        if (is_load)
            return load_lat;
        else if (is_mul)
            return mul_lat;
        else
            return alu_lat;
    endfunction

endpackage

// File: rtl/wb_slot_ring.sv
// rtl/wb_slot_ring.sv - writeback port reservation ring with per-slot destination register
module wb_slot_ring
    import issue_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  lat_t     query_lat,
    input  logic     set_en,
    input  reg_idx_t set_rd,
    output logic     conflict,
    output logic     wb_valid,
    output reg_idx_t wb_rd
);

    logic [MAX_LAT:0] res;
    reg_idx_t         rd_slot [MAX_LAT+1];

    assign conflict = res[query_lat];
    assign wb_valid = res[0];
    assign wb_rd    = res[0] ? rd_slot[0] : '0;

    // Slot i holds the writeback that happens i cycles from now; a new entry
    // lands in slot L-1 because the shift happens on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            for (int i = 0; i <= MAX_LAT; i++)
                rd_slot[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_LAT; i++) begin
                res[i]     <= res[i+1];
                rd_slot[i] <= rd_slot[i+1];
            end
            res[MAX_LAT]     <= 1'b0;
            rd_slot[MAX_LAT] <= '0;
            if (set_en) begin
                res[query_lat - lat_t'(1)]     <= 1'b1;
                rd_slot[query_lat - lat_t'(1)] <= set_rd;
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue control with RAW/WAW, writeback port and multiplier hazards
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int ALU_LAT  = ALU_LAT_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid_i,
    input  logic [REG_IDX_W-1:0]    id_rs1_i,
    input  logic [REG_IDX_W-1:0]    id_rs2_i,
    input  logic                    id_rs1_used_i,
    input  logic                    id_rs2_used_i,
    input  logic [REG_IDX_W-1:0]    id_rd_i,
    input  logic                    id_reg_write_i,
    input  logic                    id_is_load_i,
    input  logic                    id_is_mul_i,
    input  logic                    kill_i,
    output logic                    stall_o,
    output logic                    issue_o,
    output logic                    wb_valid_o,
    output logic [REG_IDX_W-1:0]    wb_rd_o,
    output logic [REG_FILE_LEN-1:0] busy_o
);

    localparam lat_t ALU_L  = lat_t'(ALU_LAT);
    localparam lat_t LOAD_L = lat_t'(LOAD_LAT);
    localparam lat_t MUL_L  = lat_t'(MUL_LAT);

    issue_req_t req;
    lat_t       cnt [REG_FILE_LEN];
    lat_t       mul_cnt;
    lat_t       lat;
    logic       mul_class;
    logic       writes;
    logic       raw, waw, wb_conflict, mul_busy, hazard;
    logic       ring_wb_valid;
    reg_idx_t   ring_wb_rd;

    assign req = '{rs1: id_rs1_i, rs2: id_rs2_i, rs1_used: id_rs1_used_i,
                   rs2_used: id_rs2_used_i, rd: id_rd_i, reg_write: id_reg_write_i,
                   is_load: id_is_load_i, is_mul: id_is_mul_i};

    assign lat       = sel_lat(req.is_load, req.is_mul, ALU_L, LOAD_L, MUL_L);
    assign mul_class = req.is_mul & ~req.is_load;
    assign writes    = req.reg_write & (req.rd != '0);

    // cnt == 1 means the producer is in WB now and its result is bypassed.
    always_comb begin
        raw = 1'b0;
        if (req.rs1_used && req.rs1 != '0 && cnt[req.rs1] > lat_t'(1))
            raw = 1'b1;
        if (req.rs2_used && req.rs2 != '0 && cnt[req.rs2] > lat_t'(1))
            raw = 1'b1;
        waw      = writes & (cnt[req.rd] > lat);
        mul_busy = mul_class & (mul_cnt > lat_t'(1));
        hazard   = raw | waw | (writes & wb_conflict) | mul_busy;
        issue_o  = ~rst & id_valid_i & ~kill_i & ~hazard;
        stall_o  = ~rst & id_valid_i & ~kill_i & hazard;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt <= '0;
            for (int r = 0; r < REG_FILE_LEN; r++)
                cnt[r] <= '0;
        end else begin
            if (issue_o && mul_class)
                mul_cnt <= MUL_L;
            else if (mul_cnt != '0)
                mul_cnt <= mul_cnt - lat_t'(1);
            for (int r = 0; r < REG_FILE_LEN; r++) begin
                if (issue_o && writes && req.rd == reg_idx_t'(r))
                    cnt[r] <= lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - lat_t'(1);
            end
        end
    end

    wb_slot_ring u_ring (
        .clk       (clk),
        .rst       (rst),
        .query_lat (lat),
        .set_en    (issue_o & writes),
        .set_rd    (req.rd),
        .conflict  (wb_conflict),
        .wb_valid  (ring_wb_valid),
        .wb_rd     (ring_wb_rd)
    );

    assign wb_valid_o = ~rst & ring_wb_valid;
    assign wb_rd_o    = rst ? '0 : ring_wb_rd;

    always_comb begin
        busy_o = '0;
        for (int r = 0; r < REG_FILE_LEN; r++)
            busy_o[r] = ~rst & (cnt[r] != '0);
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed scoreboard bench for issue_scoreboard
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid_i = 1'b0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic        id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
    logic        id_reg_write_i = 1'b0, id_is_load_i = 1'b0, id_is_mul_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        stall_o, issue_o, wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] busy_o;

    int checks = 0;
    int failures = 0;
    int vec_idx = 0;

    typedef struct {
        int          idx;
        logic        st;
        logic        is;
        logic        wv;
        logic [4:0]  rd;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q [$];

    issue_scoreboard #(.ALU_LAT(1), .LOAD_LAT(3), .MUL_LAT(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_is_load_i   (id_is_load_i),
        .id_is_mul_i    (id_is_mul_i),
        .kill_i         (kill_i),
        .stall_o        (stall_o),
        .issue_o        (issue_o),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_o        (wb_rd_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] b(input int n);
        return 32'd1 << n;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, req);
        end
    endtask

    // One cycle of ID stimulus plus its hand-computed expected outputs.
    task automatic step(input logic r, input logic v, input logic kl, input logic ld,
                        input logic mul, input logic rw, input int rd,
                        input logic u1, input int rs1, input logic u2, input int rs2,
                        input logic est, input logic eis, input logic ewv, input int erd,
                        input logic [31:0] ebusy);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid_i = v; kill_i = kl; id_is_load_i = ld; id_is_mul_i = mul;
        id_reg_write_i = rw; id_rd_i = 5'(rd); id_rs1_used_i = u1; id_rs1_i = 5'(rs1);
        id_rs2_used_i = u2; id_rs2_i = 5'(rs2);
        e.idx = vec_idx; e.st = est; e.is = eis; e.wv = ewv; e.rd = 5'(erd); e.busy = ebusy;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    task automatic idle(input logic ewv, input int erd, input logic [31:0] ebusy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ewv, erd, ebusy);
    endtask

    task automatic do_rst();
        step(1, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_o",    e.idx, 32'(stall_o),    32'(e.st));
            chk("issue_o",    e.idx, 32'(issue_o),    32'(e.is));
            chk("wb_valid_o", e.idx, 32'(wb_valid_o), 32'(e.wv));
            chk("wb_rd_o",    e.idx, 32'(wb_rd_o),    32'(e.rd));
            chk("busy_o",     e.idx, busy_o,          e.busy);
        end
    end

    initial begin
        do_rst();
        do_rst();

        // RAW after load: load x5, then add x6,x5,x1
        step(0, 1, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 6, 1, 5, 1, 1, 1, 0, 0, 0, b(5));
        step(0, 1, 0, 0, 0, 1, 6, 1, 5, 1, 1, 1, 0, 0, 0, b(5));
        step(0, 1, 0, 0, 0, 1, 6, 1, 5, 1, 1, 0, 1, 1, 5, b(5));
        idle(1, 6, b(6));
        idle(0, 0, 0);

        // Multiplier occupancy
        do_rst();
        step(0, 1, 0, 0, 1, 1, 8, 1, 1, 1, 2, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 0, 1, 1, 9, 1, 3, 1, 4, 1, 0, 0, 0, b(8));
        step(0, 1, 0, 0, 1, 1, 9, 1, 3, 1, 4, 0, 1, 1, 8, b(8));
        for (int k = 0; k < 4; k++)
            idle(0, 0, b(9));
        idle(1, 9, b(9));
        idle(0, 0, 0);

        // WB port conflict: load x3, ALU x4 presented two cycles later
        do_rst();
        step(0, 1, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0, b(3));
        step(0, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, b(3));
        step(0, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 3, b(3));
        idle(1, 4, b(4));
        idle(0, 0, 0);

        // WAW: mul x7 then ALU x7
        do_rst();
        step(0, 1, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, b(7));
        step(0, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 1, 7, b(7));
        idle(1, 7, b(7));
        idle(0, 0, 0);

        // x0 write never tracked; kill suppresses both stall and issue
        do_rst();
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1, 11, 1, 10, 0, 0, 0, 0, 0, 0, b(10));
        step(0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0, 0, 0, b(10));
        step(0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1, 1, 10, b(10));
        idle(0, 0, 0);

        // Reset mid-flight discards the pending mul
        do_rst();
        step(0, 1, 0, 0, 1, 1, 12, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0, b(12));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1, 13, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            idle(0, 0, b(13));
        idle(1, 13, b(13));
        idle(0, 0, 0);

        // Back-to-back dependent ALU ops issue every cycle
        do_rst();
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0, 1, 1, 1, b(1));
        step(0, 1, 0, 0, 0, 1, 3, 1, 2, 0, 0, 0, 1, 1, 2, b(2));
        idle(1, 3, b(3));
        idle(0, 0, 0);

        // Load+mul bits: load latency, multiplier left free
        do_rst();
        step(0, 1, 0, 1, 1, 1, 14, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1, 15, 0, 0, 0, 0, 0, 1, 0, 0, b(14));
        idle(0, 0, b(14) | b(15));
        idle(1, 14, b(14) | b(15));
        idle(0, 0, b(15));
        idle(0, 0, b(15));
        idle(1, 15, b(15));
        idle(0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
